// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: FSM encoding, default NOP and the entry payload.
package pipe_pkg;

  localparam int unsigned ENTRY_INST_W = 32;
  localparam int unsigned ENTRY_DATA_W = 32;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENTRY_INST_W-1:0] inst;
    logic [ENTRY_DATA_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] alu;
    logic [ENTRY_DATA_W-1:0] load;
  } entry_t;

  // Bubble entry as seen by downstream decode.
  function automatic entry_t nop_entry();
    entry_t e;
    e      = '0;
    e.inst = NOP_INST_DEFAULT;
    return e;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Enabled holder of one pipeline entry; clear takes priority and restores the reset value.
module pipe_entry_reg #(
  parameter int unsigned    W       = 128,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage_pipe_reg.sv
// EXE -> MEM/WB stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating stall counter.
module mem_stage_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter bit                 SKID     = 1'b1,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEFAULT),
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned ENTRY_W = INST_W + 3 * DATA_W;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] load;
  } stage_entry_t;

  localparam stage_entry_t RST_ENTRY = '{inst: NOP_INST, pc: '0, alu: '0, load: '0};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  stage_entry_t w_in_entry;
  stage_entry_t w_main_d;
  stage_entry_t w_main_q;
  stage_entry_t w_skid_q;

  logic w_main_en;
  logic w_main_clr;
  logic w_skid_en;
  logic w_skid_clr;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_valid;

  assign w_in_entry  = '{inst: in_inst, pc: in_pc, alu: in_alu, load: in_load};
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_valid = (r_state != ST_EMPTY);

  // Next state and entry-register controls; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_en   = 1'b0;
    w_skid_clr  = 1'b0;
    w_main_d    = w_in_entry;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_en   = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (w_in_fire) begin
              w_main_en = 1'b1;
            end else begin
              w_main_clr  = 1'b1;
              w_state_nxt = ST_EMPTY;
            end
          end else if (w_in_fire) begin
            // Only reachable with the skid entry: in_ready is low here otherwise.
            w_skid_en   = 1'b1;
            w_state_nxt = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            w_main_en   = 1'b1;
            w_main_d    = w_skid_q;
            w_skid_clr  = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready is a flop with the skid entry, otherwise a pass-through of downstream ready.
  if (SKID) begin : g_reg_ready
    logic r_in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_in_ready <= 1'b1;
      end else begin
        r_in_ready <= (w_state_nxt != ST_SKID);
      end
    end
    assign w_in_ready = r_in_ready;
  end else begin : g_comb_ready
    assign w_in_ready = (r_state == ST_EMPTY) | out_ready;
  end

  // Saturating count of cycles where a valid output was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  pipe_entry_reg #(
    .W       (ENTRY_W),
    .RST_VAL (RST_ENTRY)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_clr (w_main_clr),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  pipe_entry_reg #(
    .W       (ENTRY_W),
    .RST_VAL (RST_ENTRY)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_clr (w_skid_clr),
    .i_d   (w_in_entry),
    .o_q   (w_skid_q)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_inst  = w_main_q.inst;
  assign out_pc    = w_main_q.pc;
  assign out_alu   = w_main_q.alu;
  assign out_load  = w_main_q.load;
  assign stall_cnt = r_stall_cnt;

endmodule
